gate_identifier: RTL

Sequential checker that learns which 2-input logic function a device under test implements. It captures (a, b, y) samples over a valid/ready handshake, builds the 4-row truth table, and reports a gate code with a one-cycle done pulse. It sits on the observation side of the logic-gate blocks: those blocks drive y from a and b, and this block decodes a, b and y back into the gate identity for self-check benches and board demos.

---
 rtl/gate_id_pkg.sv | 38 +++
 rtl/gate_tt_decode.sv | 37 +++
 rtl/gate_identifier.sv | 138 +++++++++++++
 3 files changed

// File: rtl/gate_id_pkg.sv
// ============================================================================
// Module      : gate_id_pkg
// Description : Shared constants for the 2-input gate identifier: FSM state
//               encoding, reported gate codes and reference truth tables.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package gate_id_pkg;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CAPTURE = 2'd1;
    localparam logic [1:0] ST_DECODE  = 2'd2;
    localparam logic [1:0] ST_REPORT  = 2'd3;

    // Reported gate codes
    localparam logic [2:0] GATE_UNKNOWN = 3'd0;
    localparam logic [2:0] GATE_AND     = 3'd1;
    localparam logic [2:0] GATE_OR      = 3'd2;
    localparam logic [2:0] GATE_NOT_A   = 3'd3;
    localparam logic [2:0] GATE_XOR     = 3'd4;
    localparam logic [2:0] GATE_XNOR    = 3'd5;
    localparam logic [2:0] GATE_NOR     = 3'd6;
    localparam logic [2:0] GATE_NAND    = 3'd7;

    // Reference truth tables, bit index {a,b}
    localparam logic [3:0] TT_AND   = 4'b1000;
    localparam logic [3:0] TT_OR    = 4'b1110;
    localparam logic [3:0] TT_NOT_A = 4'b0011;
    localparam logic [3:0] TT_XOR   = 4'b0110;
    localparam logic [3:0] TT_XNOR  = 4'b1001;
    localparam logic [3:0] TT_NOR   = 4'b0001;
    localparam logic [3:0] TT_NAND  = 4'b0111;

endpackage

`default_nettype wire

// File: rtl/gate_tt_decode.sv
// ============================================================================
// Module      : gate_tt_decode
// Description : Combinational mapping of a captured 4-row truth table to a
//               gate code. Incomplete or conflicting tables decode to UNKNOWN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gate_tt_decode
    import gate_id_pkg::*;
(
    input  logic [3:0] tt_i,
    input  logic [3:0] seen_i,
    input  logic       conflict_i,
    output logic [2:0] code_o
);

    // Only a complete, consistent table can name a gate
    always_comb begin
        code_o = GATE_UNKNOWN;
        if ((seen_i == 4'hF) && !conflict_i) begin
            case (tt_i)
                TT_AND:   code_o = GATE_AND;
                TT_OR:    code_o = GATE_OR;
                TT_NOT_A: code_o = GATE_NOT_A;
                TT_XOR:   code_o = GATE_XOR;
                TT_XNOR:  code_o = GATE_XNOR;
                TT_NOR:   code_o = GATE_NOR;
                TT_NAND:  code_o = GATE_NAND;
                default:  code_o = GATE_UNKNOWN;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/gate_identifier.sv
// ============================================================================
// Module      : gate_identifier
// Description : Captures (a, b, y) samples over a valid/ready handshake,
//               builds the truth table of an observed 2-input gate and
//               reports its identity with a one-cycle done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gate_identifier
    import gate_id_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       s_valid,
    output logic       s_ready,
    input  logic       s_a,
    input  logic       s_b,
    input  logic       s_y,
    output logic       busy,
    output logic       done,
    output logic [2:0] gate_code,
    output logic       conflict,
    output logic [3:0] seen
);

    // Counter must be able to hold the value TIMEOUT itself
    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT);

    logic [1:0]       state_q, state_d;
    logic [3:0]       tt_q, tt_d;
    logic [3:0]       seen_q, seen_d;
    logic             conflict_q, conflict_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       code_q, code_d;
    logic             ready_q;

    logic             w_accept;
    logic [1:0]       w_idx;
    logic [2:0]       w_code;

    assign w_accept = s_valid & ready_q;
    assign w_idx    = {s_a, s_b};

    // Decoder sees the fully registered table while in DECODE
    gate_tt_decode u_decode (
        .tt_i       (tt_q),
        .seen_i     (seen_q),
        .conflict_i (conflict_q),
        .code_o     (w_code)
    );

    // Next-state logic: capture, timeout and decode sequencing
    always_comb begin
        state_d    = state_q;
        tt_d       = tt_q;
        seen_d     = seen_q;
        conflict_d = conflict_q;
        cnt_d      = cnt_q;
        code_d     = code_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    tt_d       = 4'b0000;
                    seen_d     = 4'b0000;
                    conflict_d = 1'b0;
                    cnt_d      = '0;
                    state_d    = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (w_accept) begin
                    // First observation of a row is kept; repeats only check it
                    if (!seen_q[w_idx]) begin
                        tt_d[w_idx]   = s_y;
                        seen_d[w_idx] = 1'b1;
                    end else if (tt_q[w_idx] != s_y) begin
                        conflict_d = 1'b1;
                    end
                    cnt_d = '0;
                    if (seen_d == 4'hF) begin
                        state_d = ST_DECODE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d == TO_LIMIT) begin
                        state_d = ST_DECODE;
                    end
                end
            end
            ST_DECODE: begin
                code_d  = w_code;
                state_d = ST_REPORT;
            end
            ST_REPORT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            tt_q       <= 4'b0000;
            seen_q     <= 4'b0000;
            conflict_q <= 1'b0;
            cnt_q      <= '0;
            code_q     <= GATE_UNKNOWN;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            tt_q       <= tt_d;
            seen_q     <= seen_d;
            conflict_q <= conflict_d;
            cnt_q      <= cnt_d;
            code_q     <= code_d;
            ready_q    <= (state_d == ST_CAPTURE);
        end
    end

    assign s_ready   = ready_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_REPORT);
    assign gate_code = code_q;
    assign conflict  = conflict_q;
    assign seen      = seen_q;

endmodule

`default_nettype wire
